// File: rtl/pat_det_if.sv
// Bus bundle between the pattern detector and the logic that drives it.
// The master side (stream source / controller) drives the control and data
// inputs. The slave side (the detector) returns status and statistics.
interface pat_det_if #(
    parameter int CNT_W = 8
);
    logic             load;
    logic [3:0]       pat_nib;
    logic             start;
    logic             stop;
    logic             valid;
    logic [3:0]       data_in;

    logic             pat_ready;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] last_pos;

    modport master (
        output load, pat_nib, start, stop, valid, data_in,
        input  pat_ready, busy, match, match_cnt, sample_cnt, last_pos
    );

    modport slave (
        input  load, pat_nib, start, stop, valid, data_in,
        output pat_ready, busy, match, match_cnt, sample_cnt, last_pos
    );
endinterface

// File: rtl/pat_det.sv
// Pattern detector for the 4-bit generator stream.
// Holds a PAT_LEN-nibble target, slides a PAT_LEN-deep window over accepted
// samples and flags every (overlapping) occurrence of the target.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for a load strobe or a start with a full pattern
// S_LOAD   | collecting pattern nibbles, one per load cycle
// S_SEARCH | shifting valid samples into the window, reporting matches
module pat_det #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic      clk,
    input  logic      res,
    pat_det_if.slave  bus
);

    localparam int IDX_W  = $clog2(PAT_LEN);
    localparam int FILL_W = $clog2(PAT_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SEARCH = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [PAT_LEN-1:0][3:0]   pat_q, pat_d;
    logic [PAT_LEN-1:0][3:0]   win_q, win_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [FILL_W-1:0]         fill_q, fill_d;
    logic                      pat_ready_q, pat_ready_d;
    logic                      match_q, match_d;
    logic [CNT_W-1:0]          match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]          sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]          last_pos_q, last_pos_d;

    logic                      load_last;
    logic                      search_go;
    logic                      accept;
    logic                      fill_full_q;
    logic                      fill_full_d;
    logic                      win_hit;

    // The nibble written this load cycle completes the pattern.
    assign load_last   = (idx_q == IDX_W'(PAT_LEN - 1));
    // Load wins over start when both arrive in IDLE.
    assign search_go   = bus.start & pat_ready_q & ~bus.load;
    // A stop in the same cycle discards the sample.
    assign accept      = (state_q == S_SEARCH) & bus.valid & ~bus.stop;
    assign fill_full_q = (fill_q == FILL_W'(PAT_LEN));
    assign fill_full_d = (fill_d == FILL_W'(PAT_LEN));
    assign win_hit     = fill_full_d & (win_d == pat_q);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= S_IDLE;
            pat_q        <= '0;
            win_q        <= '0;
            idx_q        <= '0;
            fill_q       <= '0;
            pat_ready_q  <= 1'b0;
            match_q      <= 1'b0;
            match_cnt_q  <= '0;
            sample_cnt_q <= '0;
            last_pos_q   <= '0;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            win_q        <= win_d;
            idx_q        <= idx_d;
            fill_q       <= fill_d;
            pat_ready_q  <= pat_ready_d;
            match_q      <= match_d;
            match_cnt_q  <= match_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            last_pos_q   <= last_pos_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    state_d = S_LOAD;
                end else if (search_go) begin
                    state_d = S_SEARCH;
                end
            end
            S_LOAD: begin
                if (bus.load && load_last) begin
                    state_d = S_IDLE;
                end
            end
            S_SEARCH: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pattern store, window shift, counters and match pulse.
    always_comb begin
        pat_d        = pat_q;
        win_d        = win_q;
        idx_d        = idx_q;
        fill_d       = fill_q;
        pat_ready_d  = pat_ready_q;
        match_d      = 1'b0;
        match_cnt_d  = match_cnt_q;
        sample_cnt_d = sample_cnt_q;
        last_pos_d   = last_pos_q;

        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    pat_d[0]    = bus.pat_nib;
                    idx_d       = IDX_W'(1);
                    pat_ready_d = 1'b0;
                end else if (search_go) begin
                    win_d        = '0;
                    fill_d       = '0;
                    match_cnt_d  = '0;
                    sample_cnt_d = '0;
                    last_pos_d   = '0;
                end
            end
            S_LOAD: begin
                if (bus.load) begin
                    pat_d[idx_q] = bus.pat_nib;
                    idx_d        = idx_q + IDX_W'(1);
                    if (load_last) begin
                        pat_ready_d = 1'b1;
                    end
                end
            end
            S_SEARCH: begin
                if (accept) begin
                    // Index 0 holds the oldest sample, PAT_LEN-1 the newest,
                    // so the window lines up element-wise with the pattern.
                    for (int i = 0; i < PAT_LEN - 1; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[PAT_LEN-1] = bus.data_in;

                    if (!fill_full_q) begin
                        fill_d = fill_q + FILL_W'(1);
                    end

                    if (sample_cnt_q != '1) begin
                        sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    end

                    if (win_hit) begin
                        match_d    = 1'b1;
                        last_pos_d = sample_cnt_d;
                        if (match_cnt_q != '1) begin
                            match_cnt_d = match_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.pat_ready  = pat_ready_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.match      = match_q;
    assign bus.match_cnt  = match_cnt_q;
    assign bus.sample_cnt = sample_cnt_q;
    assign bus.last_pos   = last_pos_q;

endmodule

// File: doc/pat_det.md
# pat_det

Pattern detector for the 4-bit pseudo-random stream produced by the pattern generator. It holds a programmable target sequence of `PAT_LEN` nibbles, watches the `data_in` stream, and reports every occurrence of that sequence. Overlapping occurrences count. It sits at the receive end of the generator output and reports match pulses, a match counter and the position of the last match to the system.

## Interface
- `PAT_LEN`, default 4: number of nibbles in the target pattern (legal 2..8).
- `CNT_W`, default 8: width of `match_cnt` and `sample_cnt`.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `res`  in  1  reset, synchronous, active-high.
- `load`  in  1  pattern-load strobe; one nibble is taken per cycle.
- `pat_nib`  in  4  pattern nibble, sampled when `load`=1.
- `start`  in  1  enter the search state.
- `stop`  in  1  leave the search state.
- `valid`  in  1  `data_in` is a live sample this cycle.
- `data_in`  in  4  stream nibble from the generator.
- `pat_ready`  out  1  a full pattern has been loaded.
- `busy`  out  1  high in LOAD or SEARCH.
- `match`  out  1  one-cycle pulse per detected occurrence.
- `match_cnt`  out  CNT_W  matches since the last start; saturating.
- `sample_cnt`  out  CNT_W  valid samples accepted since the last start; saturating.
- `last_pos`  out  CNT_W  `sample_cnt` value of the sample that completed the most recent match.

## Operation
- States are IDLE, LOAD and SEARCH. On reset the block enters IDLE.
- Reset values:
  - All outputs are 0.
  - Pattern registers, history window and fill counter are cleared.
- From IDLE:
  - `load`=1 stores `pat_nib` as pattern[0], sets the load index to 1, clears `pat_ready` and moves to LOAD.
  - `load` has priority over `start` in the same cycle.
  - `start`=1 with `pat_ready`=1 moves to SEARCH. The same edge clears `match_cnt`, `sample_cnt`, `last_pos`, the window and the fill counter.
  - `start` with `pat_ready`=0 is ignored and the block stays in IDLE.
- In LOAD:
  - Each `load`=1 cycle stores `pat_nib` at pattern[index] and increments the index.
  - Cycles with `load`=0 hold state.
  - When pattern[PAT_LEN-1] is written, `pat_ready` is set to 1 on that same edge and the block returns to IDLE.
  - `start` and `stop` are ignored in LOAD.
- In SEARCH:
  - A `valid`=1 cycle shifts `data_in` into a PAT_LEN-deep window. The oldest entry is compared against pattern[0] and the newest against pattern[PAT_LEN-1].
  - The same cycle increments `sample_cnt` and increments the fill counter, which saturates at PAT_LEN.
  - A `valid`=0 cycle leaves the window and counters unchanged; gaps do not break a sequence.
  - A match requires a full window (fill = PAT_LEN after the shift) that equals the pattern. On a match:
    - `match` pulses;
    - `match_cnt` increments;
    - `last_pos` takes the post-increment `sample_cnt`.
  - Overlap is allowed: the window is not cleared after a match.
  - `stop`=1 returns the block to IDLE. A `valid` sample in the same cycle is discarded. The counters and `last_pos` hold their values.
  - `load` is ignored in SEARCH.
- Counter width: `match_cnt` and `sample_cnt` saturate at 2^CNT_W-1 and never wrap. `last_pos` follows the saturated value.
- `busy` is 1 exactly while the state is LOAD or SEARCH.

## Timing
- Detection latency is one cycle. `match` is high in the cycle after the posedge that accepted the completing sample.
- `match_cnt`, `last_pos` and `sample_cnt` update on that same edge.
- The highest match rate is one pulse per valid cycle, reached with overlapping or repeating patterns.
- Entry into SEARCH takes one edge. The first sample can be accepted in the cycle after `start`; `valid` in the `start` cycle itself is ignored.
- `pat_ready` becomes 1 in the cycle after the final load nibble.
- Reset asserted in any state takes effect at the next edge:
  - all outputs return to 0;
  - the state becomes IDLE;
  - the pattern is lost.
- Reset has priority over every other input.

## Test plan
- Basic match:
  - Stimulus: load A,3,5,C; start; stream 1,A,3,5,C,7.
  - Required: one `match` after the sample C; `match_cnt`=1, `last_pos`=5, `sample_cnt`=6.
- Overlap:
  - Stimulus: pattern 1,1,1,1; stream seven 1s.
  - Required: matches on samples 4,5,6,7; `match_cnt`=4, `last_pos`=7.
- Valid gaps:
  - Stimulus: pattern A,3,5,C; insert 3 `valid`=0 cycles between each sample.
  - Required: still one match, and no pulse during the gap cycles.
- Control corners:
  - `start` with no pattern loaded: state stays IDLE and `busy`=0.
  - `load`+`start` together: LOAD is entered.
  - `stop`+`valid` with the completing nibble: no match, and `match_cnt` is unchanged.
- Saturation:
  - Stimulus: CNT_W=4; pattern 0,0; stream twenty 0s.
  - Required: `match_cnt` and `sample_cnt` hold at 15.
- Reset mid-operation:
  - Stimulus: assert `res` during SEARCH after 2 matches.
  - Required: next cycle all outputs are 0 and `pat_ready`=0; a following `start` is ignored.
